// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared types, default parameters and the round-robin pick
//               function for the SPI chip-select arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

  localparam int DEF_NUM_REQ       = 2;
  localparam int DEF_CS_SETUP_CLKS = 2;
  localparam int DEF_CS_HOLD_CLKS  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARB      = 3'd1,
    CS_SETUP = 3'd2,
    XFER     = 3'd3,
    CS_HOLD  = 3'd4
  } arb_state_e;

  // First set bit of req at or after ptr, wrapping modulo 8. Callers zero the
  // bits above their requester count and keep ptr below it, so wrapping
  // modulo 8 visits the live requesters in the same order as wrapping modulo
  // the real count. Returns 0 when nothing is requesting.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    sel   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_arbiter
// Description : Combinational round-robin select plus a registered pointer
//               that moves past the winner on each update strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       update,
  output logic [$clog2(NUM_REQ)-1:0] pick
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] ptr;

  // Select the first requester at or after the pointer
  always_comb begin
    pick = IDX_W'(rr_pick(8'(req), 3'(ptr)));
  end

  // Advance the pointer past the winner when a grant is taken
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (pick == LAST_IDX) ? '0 : pick + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_cs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_cs_arbiter
// Description : Shares one byte-level SPI master between NUM_REQ requesters,
//               owns their chip selects and enforces CS setup/hold gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cs_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int CS_SETUP_CLKS = DEF_CS_SETUP_CLKS,
  parameter int CS_HOLD_CLKS  = DEF_CS_HOLD_CLKS
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req,
  output logic [NUM_REQ-1:0]   o_Gnt,
  input  logic [NUM_REQ*8-1:0] i_Req_TX_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_TX_DV,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_TX_Ready,
  output logic [NUM_REQ-1:0]   o_Req_RX_DV,
  output logic [7:0]           o_Req_RX_Byte,
  output logic [NUM_REQ-1:0]   o_CS_n,
  output logic [7:0]           o_TX_Byte,
  output logic                 o_TX_DV,
  input  logic                 i_TX_Ready,
  input  logic                 i_RX_DV,
  input  logic [7:0]           i_RX_Byte,
  output logic                 o_Busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD_CLKS - 1);

  arb_state_e         state;
  arb_state_e         next_state;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   pick;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] pick_oh;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_done;
  logic               pending;
  logic               last_sent;
  logic               sel_dv;
  logic               sel_last;
  logic [7:0]         sel_byte;
  logic               ready;
  logic               accept;
  logic               rx_take;
  logic               arb_update;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .req     (i_Req),
    .update  (arb_update),
    .pick    (pick)
  );

  // Decode the granted and picked lanes and mux the granted requester's inputs
  always_comb begin
    gnt_oh   = '0;
    pick_oh  = '0;
    sel_dv   = 1'b0;
    sel_last = 1'b0;
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_oh[k]  = (gnt_idx == IDX_W'(k));
      pick_oh[k] = (pick == IDX_W'(k));
      if (gnt_idx == IDX_W'(k)) begin
        sel_dv   = i_Req_TX_DV[k];
        sel_last = i_Req_Last[k];
        sel_byte = i_Req_TX_Byte[8*k +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a burst only ends on the RX of its last byte
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (|i_Req) next_state = ARB;
      ARB:      next_state = CS_SETUP;
      CS_SETUP: if (cnt_done) next_state = XFER;
      XFER:     if (rx_take && last_sent) next_state = CS_HOLD;
      CS_HOLD:  if (cnt_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Combinational outputs and handshake strobes; one byte in flight at most
  always_comb begin
    o_Busy         = (state != IDLE);
    arb_update     = (state == ARB);
    cnt_done       = (cnt == '0);
    ready          = (state == XFER) && i_TX_Ready && !pending && !last_sent;
    accept         = ready && sel_dv;
    rx_take        = (state == XFER) && pending && i_RX_DV;
    o_Req_TX_Ready = ready ? gnt_oh : '0;
  end

  // Registered grant, chip select, gap counter and byte forwarding
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      gnt_idx       <= '0;
      o_Gnt         <= '0;
      o_CS_n        <= '1;
      cnt           <= '0;
      pending       <= 1'b0;
      last_sent     <= 1'b0;
      o_TX_Byte     <= '0;
      o_TX_DV       <= 1'b0;
      o_Req_RX_Byte <= '0;
      o_Req_RX_DV   <= '0;
    end else begin
      o_TX_DV     <= 1'b0;
      o_Req_RX_DV <= '0;
      case (state)
        ARB: begin
          gnt_idx <= pick;
          o_Gnt   <= pick_oh;
          o_CS_n  <= ~pick_oh;
          cnt     <= SETUP_LOAD;
        end
        CS_SETUP: begin
          if (!cnt_done) cnt <= cnt - CNT_W'(1);
        end
        XFER: begin
          if (accept) begin
            pending   <= 1'b1;
            last_sent <= sel_last;
            o_TX_Byte <= sel_byte;
            o_TX_DV   <= 1'b1;
          end
          if (rx_take) begin
            pending       <= 1'b0;
            o_Req_RX_Byte <= i_RX_Byte;
            o_Req_RX_DV   <= gnt_oh;
            if (last_sent) cnt <= HOLD_LOAD;
          end
        end
        CS_HOLD: begin
          if (cnt_done) begin
            o_Gnt     <= '0;
            o_CS_n    <= '1;
            last_sent <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cs_arbiter
// Description : Scoreboard bench for spi_cs_arbiter with an echoing SPI
//               master model (returns ~byte three cycles after each TX).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cs_arbiter;

  localparam int N     = 2;
  localparam int SETUP = 4;
  localparam int HOLD  = 3;

  logic           clk = 1'b0;
  logic           rst_l = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*8-1:0] tx_data = '0;
  logic [N-1:0]   tx_dv = '0;
  logic [N-1:0]   tx_last = '0;
  logic           tx_ready = 1'b1;
  logic           rx_dv = 1'b0;
  logic [7:0]     rx_byte = '0;

  logic [N-1:0]   o_Gnt;
  logic [N-1:0]   o_Req_TX_Ready;
  logic [N-1:0]   o_Req_RX_DV;
  logic [7:0]     o_Req_RX_Byte;
  logic [N-1:0]   o_CS_n;
  logic [7:0]     o_TX_Byte;
  logic           o_TX_DV;
  logic           o_Busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int rsp_cnt = 0;
  int rx_events = 0;
  int rx_cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  bit have_rise = 0;
  bit want_ready = 0;
  bit mon_en = 0;
  int spur_req = 0;
  int spur_ack = 0;

  logic [7:0] tx_q [$];
  int         rx_q [$];
  int         gnt_q [$];
  logic [7:0] burst_data [8];

  spi_cs_arbiter #(
    .NUM_REQ       (N),
    .CS_SETUP_CLKS (SETUP),
    .CS_HOLD_CLKS  (HOLD)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_l),
    .i_Req          (req),
    .o_Gnt          (o_Gnt),
    .i_Req_TX_Byte  (tx_data),
    .i_Req_TX_DV    (tx_dv),
    .i_Req_Last     (tx_last),
    .o_Req_TX_Ready (o_Req_TX_Ready),
    .o_Req_RX_DV    (o_Req_RX_DV),
    .o_Req_RX_Byte  (o_Req_RX_Byte),
    .o_CS_n         (o_CS_n),
    .o_TX_Byte      (o_TX_Byte),
    .o_TX_DV        (o_TX_DV),
    .i_TX_Ready     (tx_ready),
    .i_RX_DV        (rx_dv),
    .i_RX_Byte      (rx_byte),
    .o_Busy         (o_Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Echoing SPI master: answers each TX byte with its complement.
  task automatic master_loop();
    int         resp_wait = 0;
    logic [7:0] resp_byte = '0;
    forever begin
      @(negedge clk);
      rx_dv = 1'b0;
      if (!rst_l) begin
        if (resp_wait > 0) rsp_cnt++;
        resp_wait = 0;
      end else if (resp_wait > 0) begin
        resp_wait--;
        if (resp_wait == 0) begin
          rx_dv   = 1'b1;
          rx_byte = ~resp_byte;
          rsp_cnt++;
        end
      end else if (spur_req != spur_ack) begin
        rx_dv    = 1'b1;
        rx_byte  = 8'h77;
        spur_ack = spur_req;
      end
      if (o_TX_DV && rst_l) begin
        resp_wait = 3;
        resp_byte = o_TX_Byte;
      end
    end
  endtask

  // Output monitor: pops scoreboards and checks pulse widths and CS timing.
  task automatic monitor_loop();
    logic [N-1:0] prev_gnt  = '0;
    logic [N-1:0] prev_rxdv = '0;
    logic [N-1:0] prev_cs   = '1;
    logic         prev_txdv = 1'b0;
    int           k_exp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_TX_DV) begin
          check("txdv_1cyc", int'(prev_txdv), 0);
          check("one_outstanding", tx_cnt - rsp_cnt, 0);
          tx_cnt++;
          if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
          else check("tx_byte", int'(o_TX_Byte), int'(tx_q.pop_front()));
        end
        if (o_Req_RX_DV != '0) begin
          rx_events++;
          rx_cyc = cyc;
          check("rxdv_1cyc", int'(prev_rxdv), 0);
          if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
          else check("rx_lane_byte", int'({o_Req_RX_DV, o_Req_RX_Byte}), rx_q.pop_front());
        end
        if (prev_gnt == '0 && o_Gnt != '0) begin
          if (gnt_q.size() == 0) begin
            check("gnt_unexpected", 1, 0);
            k_exp = 0;
          end else begin
            k_exp = gnt_q.pop_front();
          end
          check("gnt", int'(o_Gnt), 1 << k_exp);
          check("cs_n_at_gnt", int'(o_CS_n), ((1 << N) - 1) ^ (1 << k_exp));
          if (have_rise) check("cs_gap_ge2", int'((cyc - rise_cyc) >= 2), 1);
          fall_cyc   = cyc;
          want_ready = 1;
        end
        if (want_ready && o_Req_TX_Ready != '0) begin
          check("setup_clks", cyc - fall_cyc, SETUP);
          want_ready = 0;
        end
        if (prev_cs != '1 && o_CS_n == '1) begin
          check("hold_clks", cyc - rx_cyc, HOLD);
          rise_cyc  = cyc;
          have_rise = 1;
        end
      end
      prev_gnt  = o_Gnt;
      prev_rxdv = o_Req_RX_DV;
      prev_cs   = o_CS_n;
      prev_txdv = o_TX_DV;
    end
  endtask

  task automatic wait_gnt_bit(input int k, output bit ok);
    for (int t = 0; t < 40 && !o_Gnt[k]; t++) @(negedge clk);
    ok = o_Gnt[k];
    if (!ok) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_any_gnt(output int k, output bit ok);
    k = 0;
    for (int t = 0; t < 40 && o_Gnt == '0; t++) @(negedge clk);
    ok = (o_Gnt != '0);
    if (!ok) check("any_gnt_timeout", 0, 1);
    for (int r = 0; r < N; r++) if (o_Gnt[r]) k = r;
  endtask

  task automatic wait_ready(input int k, output bit ok);
    for (int t = 0; t < 40 && !o_Req_TX_Ready[k]; t++) @(negedge clk);
    ok = o_Req_TX_Ready[k];
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  // Push one byte's expectations at the negedge before its accepting edge.
  task automatic expect_byte(input int k, input logic [7:0] b);
    logic [7:0] inv;
    inv = ~b;
    tx_q.push_back(b);
    rx_q.push_back(((1 << k) << 8) | int'(inv));
  endtask

  // Drive a burst on lane k with DV held high throughout.
  task automatic send_burst(input int k, input int n, input bit drop_mid,
                            input bit keep_req, output bit ok);
    wait_gnt_bit(k, ok);
    if (!ok) return;
    for (int i = 0; i < n; i++) begin
      tx_data[8*k +: 8] = burst_data[i];
      tx_dv[k]   = 1'b1;
      tx_last[k] = (i == n - 1);
      if (drop_mid && i == 1) req[k] = 1'b0;
      wait_ready(k, ok);
      if (!ok) begin
        tx_dv[k] = 1'b0;
        return;
      end
      check("cs_low_in_burst", int'(o_CS_n[k]), 0);
      check("busy_in_burst", int'(o_Busy), 1);
      expect_byte(k, burst_data[i]);
      @(negedge clk);
    end
    tx_dv[k]   = 1'b0;
    tx_last[k] = 1'b0;
    if (!keep_req) req[k] = 1'b0;
    for (int t = 0; t < 60 && o_Gnt != '0; t++) @(negedge clk);
    if (o_Gnt != '0) begin
      check("gnt_release_timeout", 0, 1);
      ok = 0;
    end
  endtask

  // One-byte bursts from all requesters held high; order checked by monitor.
  task automatic rr_bursts(input int nb, input int per_req);
    int remaining [N];
    int k;
    bit ok;
    for (int r = 0; r < N; r++) remaining[r] = per_req;
    req = '1;
    for (int j = 0; j < nb; j++) begin
      wait_any_gnt(k, ok);
      if (!ok) return;
      burst_data[0] = 8'(8'h40 + j);
      send_burst(k, 1, 1'b0, remaining[k] > 1, ok);
      if (!ok) return;
      remaining[k]--;
    end
  endtask

  initial begin
    bit ok;
    int ev0;
    fork
      master_loop();
      monitor_loop();
    join_none

    // Reset values
    #1 rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", int'(o_CS_n), 3);
    check("rst_gnt", int'(o_Gnt), 0);
    check("rst_txdv", int'(o_TX_DV), 0);
    check("rst_rxdv", int'(o_Req_RX_DV), 0);
    check("rst_txbyte", int'(o_TX_Byte), 0);
    check("rst_rxbyte", int'(o_Req_RX_Byte), 0);
    check("rst_busy", int'(o_Busy), 0);
    rst_l  = 1'b1;
    mon_en = 1;
    @(negedge clk);

    // Simultaneous requests from reset alternate 0,1,0,1
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
    rr_bursts(4, 2);
    repeat (4) @(negedge clk);

    // Three-byte burst on requester 0, DV held high across bytes
    gnt_q.push_back(0);
    burst_data[0] = 8'hA5; burst_data[1] = 8'h3C; burst_data[2] = 8'hFF;
    req[0] = 1'b1;
    send_burst(0, 3, 1'b0, 1'b0, ok);
    repeat (4) @(negedge clk);

    // Spurious master RX while idle must not reach any requester
    ev0 = rx_events;
    spur_req++;
    repeat (6) @(negedge clk);
    check("spurious_rx", rx_events - ev0, 0);
    check("busy_idle", int'(o_Busy), 0);

    // Request dropped mid-burst: burst still runs to its last byte
    gnt_q.push_back(0);
    burst_data[0] = 8'h11; burst_data[1] = 8'h22; burst_data[2] = 8'h33;
    req[0] = 1'b1;
    send_burst(0, 3, 1'b1, 1'b0, ok);
    repeat (4) @(negedge clk);

    // Reset while a byte is pending in XFER
    gnt_q.push_back(0);
    req[0] = 1'b1;
    wait_gnt_bit(0, ok);
    tx_data[7:0] = 8'h99;
    tx_dv[0]     = 1'b1;
    tx_last[0]   = 1'b0;
    wait_ready(0, ok);
    if (ok) expect_byte(0, 8'h99);
    @(negedge clk);
    #2;
    mon_en = 0;
    rst_l  = 1'b0;
    #1;
    check("midrst_cs_n", int'(o_CS_n), 3);
    check("midrst_gnt", int'(o_Gnt), 0);
    check("midrst_busy", int'(o_Busy), 0);
    check("midrst_txdv", int'(o_TX_DV), 0);
    req   = '0;
    tx_dv = '0;
    tx_q.delete();
    rx_q.delete();
    repeat (3) @(negedge clk);
    rst_l  = 1'b1;
    mon_en = 1;
    @(negedge clk);

    // Pointer is back at 0 after reset
    gnt_q.push_back(0); gnt_q.push_back(1);
    rr_bursts(2, 1);
    repeat (6) @(negedge clk);

    check("tx_q_drained", tx_q.size(), 0);
    check("rx_q_drained", rx_q.size(), 0);
    check("gnt_q_drained", gnt_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spi_cs_arbiter.md
# spi_cs_arbiter

Shares one byte-level SPI master controller between `NUM_REQ` requesters and owns the per-requester chip selects. Each requester issues a multi-byte burst, ended by a last-byte flag. The arbiter grants requesters round-robin and holds the chip select low for the whole burst, with programmable setup and hold gaps. It forwards TX bytes one at a time to the master and routes RX bytes back to the granted requester. It sits between the client logic and the SPI master's `i_TX_Byte/i_TX_DV/o_TX_Ready/o_RX_DV/o_RX_Byte` port.

## Interface

Parameters:
- `NUM_REQ`, default 2, number of requesters; legal range 2..8.
- `CS_SETUP_CLKS`, default 2, cycles from CS_n falling to first byte accept; must be ≥1.
- `CS_HOLD_CLKS`, default 2, cycles from last RX byte to CS_n rising; must be ≥1.

Ports:
- `i_Clk`  in  1  clock.
- `i_Rst_L`  in  1  reset; asynchronous, active-low.
- `i_Req`  in  NUM_REQ  burst request, one bit per requester.
- `o_Gnt`  out  NUM_REQ  one-hot grant, high for the whole burst.
- `i_Req_TX_Byte`  in  NUM_REQ*8  TX bytes; requester k uses bits [8k+7:8k].
- `i_Req_TX_DV`  in  NUM_REQ  byte valid.
- `i_Req_Last`  in  NUM_REQ  final byte of the burst; qualified by DV.
- `o_Req_TX_Ready`  out  NUM_REQ  byte accept enable.
- `o_Req_RX_DV`  out  NUM_REQ  one-cycle RX pulse to the granted requester.
- `o_Req_RX_Byte`  out  8  RX byte, shared; qualified by `o_Req_RX_DV`.
- `o_CS_n`  out  NUM_REQ  active-low chip selects.
- `o_TX_Byte`  out  8  to the master.
- `o_TX_DV`  out  1  to the master; one-cycle pulse.
- `i_TX_Ready`  in  1  from the master.
- `i_RX_DV`  in  1  from the master.
- `i_RX_Byte`  in  8  from the master.
- `o_Busy`  out  1  high when state is not IDLE.

## Operation

- FSM states: IDLE → ARB → CS_SETUP → XFER → CS_HOLD → IDLE.
- **IDLE:** when any `i_Req` is high, go to ARB. Otherwise stay in IDLE.
- **ARB:** select the first requesting index at or after the round-robin pointer, wrapping around. Then:
  - register the grant index `g`;
  - drive `o_Gnt[g]` high and `o_CS_n[g]` low;
  - set pointer to `(g+1) mod NUM_REQ`;
  - go to CS_SETUP.
- **CS_SETUP:** count `CS_SETUP_CLKS` cycles, then go to XFER.
- **XFER:**
  - `o_Req_TX_Ready[g] = i_TX_Ready & ~pending & ~last_sent`. This is combinational. Every other ready bit is 0.
  - Accept occurs when `i_Req_TX_DV[g]` and `o_Req_TX_Ready[g]` are both high. On accept: set `pending`; latch `i_Req_Last[g]` into `last_sent`; register the byte onto `o_TX_Byte`; pulse `o_TX_DV` for one cycle.
  - On `i_RX_DV`: clear `pending`; drive `o_Req_RX_Byte` and pulse `o_Req_RX_DV[g]` one cycle later.
  - If `last_sent` is set when the RX byte arrives, go to CS_HOLD.
  - At most one byte is outstanding at any time.
- **CS_HOLD:** count `CS_HOLD_CLKS` cycles. Then deassert `o_CS_n[g]` and `o_Gnt[g]`, clear `last_sent`, and go to IDLE.
- **Requests during a burst:**
  - `i_Req` deasserting mid-burst is ignored. Only the last byte ends a burst.
  - New requests wait until IDLE. There is no preemption and no timeout.
- **Ignored inputs:**
  - `i_RX_DV` outside XFER, or with `pending` clear, is dropped.
  - `i_Req_TX_DV` on a non-granted index is ignored.
- **Reset values:** all outputs reset, including mid-burst.
  - `o_CS_n` = all ones.
  - `o_Gnt`, `o_TX_DV`, `o_Req_RX_DV` = 0.
  - `o_TX_Byte`, `o_Req_RX_Byte` = 0.
  - `o_Busy` = 0.
  - Internal: pointer = 0, state = IDLE, `pending` and `last_sent` cleared.

## Timing

- `i_Req` sampled at edge E0 → ARB at E1. `o_Gnt` and `o_CS_n` change at E2.
- First ready possible at E2+`CS_SETUP_CLKS`.
- Accept at edge A → `o_TX_DV` high for cycle A..A+1 only.
- `i_RX_DV` sampled at edge R → `o_Req_RX_DV` high for R+1..R+2.
- Last RX at R → CS_HOLD from R+1. `o_CS_n` rises at R+1+`CS_HOLD_CLKS`.
- There is at least one IDLE and one ARB cycle between bursts. CS_n is therefore high for at least 2 cycles between bursts.
- Counter width is `$clog2(max(CS_SETUP_CLKS, CS_HOLD_CLKS)+1)`. Counters load N-1 and decrement to 0; no wrap.
- Grant index width is `$clog2(NUM_REQ)`.

## Structure

- Package `spi_arb_pkg` holds:
  - `arb_state_e` enum with IDLE, ARB, CS_SETUP, XFER, CS_HOLD;
  - default parameter constants;
  - function `rr_pick(req, ptr)`.
- Sub-module `spi_rr_arbiter`: combinational round-robin select over `NUM_REQ` plus a registered pointer with an update strobe. It is instantiated once.

## Test plan

- Single requester 0, three bytes 0xA5, 0x3C, 0xFF (last), master echoes ~byte → `CS_n[0]` low for the whole burst; RX bytes 0x5A, 0xC3, 0x00 delivered to requester 0; `o_TX_DV` is a 1-cycle pulse per byte.
- Requesters 0 and 1 request simultaneously from reset → grants in order 0, 1, 0, 1 over four one-byte bursts; `CS_n` never low on both at once; gap between bursts ≥2 cycles.
- `CS_SETUP_CLKS`=4, `CS_HOLD_CLKS`=3 → first ready exactly 4 cycles after CS_n falls; CS_n rises exactly 3 cycles after the last `o_Req_RX_DV` source edge.
- Requester holds DV high continuously → exactly one byte outstanding; second accept only after `i_RX_DV`; a spurious `i_RX_DV` in IDLE produces no `o_Req_RX_DV`.
- Assert reset mid-XFER with a byte pending → same-cycle `o_CS_n` = all ones and `o_Gnt` = 0; after release the next grant goes to requester 0.
- Requester drops `i_Req` mid-burst → burst continues until Last; `CS_n` stays low throughout.
